// File: rtl/fib_video_pkg.sv
// fib_video_pkg: shared video constants and types for the Fireboy sprite path.
package fib_video_pkg;
    localparam int H_VISIBLE = 640;
    localparam int V_VISIBLE = 480;
    localparam int PIPE_LAT = 2;
    typedef logic [3:0] pal_idx_t;
    localparam pal_idx_t TRANSPARENT_IDX = 4'd0;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       facing;
    } sprite_pose_t;
    // 11-bit compare so a box hanging past the last column/row never wraps to 0
    function automatic logic in_span(input logic [9:0] c, input logic [9:0] p, input logic [10:0] len);
        return ({1'b0, c} >= {1'b0, p}) && ({1'b0, c} < {1'b0, p} + len);
    endfunction
endpackage

// File: rtl/fireboy_sprite_fetch_if.sv
// fireboy_sprite_fetch_if: sprite ROM read port (address out, palette index back).
interface fireboy_sprite_fetch_if #(parameter int ROM_AW = 12);
    import fib_video_pkg::*;
    logic [ROM_AW-1:0] rom_addr;
    pal_idx_t          rom_data;
    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/fireboy_anim_ctr.sv
// fireboy_anim_ctr: frame-start detect and walk-animation frame counter.
module fireboy_anim_ctr #(
    parameter int NUM_FRAMES = 4,
    parameter int ANIM_DIV = 6,
    localparam int FW = $clog2(NUM_FRAMES),
    localparam int DW = $clog2(ANIM_DIV)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          frame_clk,
    input  logic          moving,
    output logic          fs,
    output logic [FW-1:0] anim_frame
);
    logic          frame_clk_q;
    logic [DW-1:0] div;
    assign fs = frame_clk & ~frame_clk_q;
    // frame 0 is the idle pose, so walking cycles through 1..NUM_FRAMES-1 only
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            frame_clk_q <= 1'b0;
            div         <= '0;
            anim_frame  <= '0;
        end else begin
            frame_clk_q <= frame_clk;
            if (fs) begin
                if (!moving) begin
                    div        <= '0;
                    anim_frame <= '0;
                end else if (div == DW'(ANIM_DIV - 1)) begin
                    div        <= '0;
                    anim_frame <= (anim_frame == FW'(NUM_FRAMES - 1)) ? FW'(1) : anim_frame + 1'b1;
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fireboy_sprite_fetch.sv
// fireboy_sprite_fetch: two-stage per-pixel sprite fetch producing is_fireboy and
// fireboy_data for the colour mapper; pose is latched once per frame.
module fireboy_sprite_fetch
    import fib_video_pkg::*;
#(
    parameter int SPRITE_W = 24,
    parameter int SPRITE_H = 32,
    parameter int NUM_FRAMES = 4,
    parameter int ANIM_DIV = 6,
    parameter int ROM_AW = 12
) (
    input  logic                          Clk,
    input  logic                          Reset_n,
    input  logic                          frame_clk,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [9:0]                    fireboy_x,
    input  logic [9:0]                    fireboy_y,
    input  logic                          facing_left,
    input  logic                          moving,
    fireboy_sprite_fetch_if.master        rom,
    output logic                          is_fireboy,
    output logic [7:0]                    fireboy_data
);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int CW = $clog2(SPRITE_W);
    localparam int RW = $clog2(SPRITE_H);
    logic              fs;
    logic [FW-1:0]     anim_frame;
    sprite_pose_t      pose;
    logic              hit;
    logic              hit_q;
    logic [CW-1:0]     col_raw;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [ROM_AW-1:0] addr;

    fireboy_anim_ctr #(.NUM_FRAMES(NUM_FRAMES), .ANIM_DIV(ANIM_DIV)) u_anim (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .moving     (moving),
        .fs         (fs),
        .anim_frame (anim_frame)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            pose <= '0;
        else if (fs)
            pose <= '{x: fireboy_x, y: fireboy_y, facing: facing_left};
    end

    // offsets are only used inside the box, so truncation to sprite size is safe
    always_comb begin
        hit     = in_span(DrawX, pose.x, 11'(SPRITE_W)) && in_span(DrawY, pose.y, 11'(SPRITE_H));
        col_raw = CW'(DrawX - pose.x);
        row     = RW'(DrawY - pose.y);
        col     = pose.facing ? CW'(SPRITE_W - 1) - col_raw : col_raw;
        addr    = ROM_AW'(anim_frame) * ROM_AW'(SPRITE_W * SPRITE_H)
                + ROM_AW'(row) * ROM_AW'(SPRITE_W) + ROM_AW'(col);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom.rom_addr <= '0;
            hit_q        <= 1'b0;
            is_fireboy   <= 1'b0;
            fireboy_data <= '0;
        end else begin
            if (hit)
                rom.rom_addr <= addr;
            hit_q        <= hit;
            is_fireboy   <= hit_q;
            fireboy_data <= {4'b0, hit_q ? rom.rom_data : TRANSPARENT_IDX};
        end
    end
endmodule

// File: tb/tb_fireboy_sprite_fetch.sv
// tb_fireboy_sprite_fetch: directed plus randomized scan against a per-pixel
// behavioural model of sprite geometry, mirroring and walk animation.
module tb_fireboy_sprite_fetch;
    import fib_video_pkg::*;
    localparam int W = 24;
    localparam int H = 32;
    localparam int NF = 4;
    localparam int DIV = 6;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b1;
    logic       frame_clk = 1'b0;
    logic       facing_left = 1'b0;
    logic       moving = 1'b0;
    logic [9:0] DrawX = '0;
    logic [9:0] DrawY = '0;
    logic [9:0] fireboy_x = '0;
    logic [9:0] fireboy_y = '0;
    logic       is_fireboy;
    logic [7:0] fireboy_data;
    logic [3:0] rom_mem [4096];
    int checks = 0;
    int errors = 0;

    int m_x, m_y, m_cnt, m_addr, m_addr_prev;
    bit m_face, m_fclk, m_hit, m_hit_prev;

    fireboy_sprite_fetch_if #(.ROM_AW(12)) rom_if ();
    assign rom_if.rom_data = rom_mem[rom_if.rom_addr];

    fireboy_sprite_fetch dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_clk    (frame_clk),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .fireboy_x    (fireboy_x),
        .fireboy_y    (fireboy_y),
        .facing_left  (facing_left),
        .moving       (moving),
        .rom          (rom_if.master),
        .is_fireboy   (is_fireboy),
        .fireboy_data (fireboy_data)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int anim_of(input int fs_count);
        int steps = fs_count / DIV;
        return steps == 0 ? 0 : (steps - 1) % (NF - 1) + 1;
    endfunction

    task automatic model_reset();
        m_x = 0; m_y = 0; m_cnt = 0; m_face = 0; m_fclk = 0;
        m_hit = 0; m_addr = 0; m_hit_prev = 0; m_addr_prev = 0;
    endtask

    // present one pixel, advance one clock, compare against the model
    task automatic tick(input int x, input int y);
        int dx, dy;
        DrawX = 10'(x);
        DrawY = 10'(y);
        dx = x - m_x;
        dy = y - m_y;
        m_hit_prev  = m_hit;
        m_addr_prev = m_addr;
        m_hit = dx >= 0 && dx < W && dy >= 0 && dy < H;
        if (m_hit)
            m_addr = anim_of(m_cnt) * W * H + dy * W + (m_face ? W - 1 - dx : dx);
        if (frame_clk && !m_fclk) begin
            m_x = int'(fireboy_x);
            m_y = int'(fireboy_y);
            m_face = facing_left;
            m_cnt = moving ? m_cnt + 1 : 0;
        end
        m_fclk = frame_clk;
        @(posedge Clk);
        #1;
        chk("rom_addr", int'(rom_if.rom_addr), m_addr);
        chk("is_fireboy", int'(is_fireboy), int'(m_hit_prev));
        chk("fireboy_data", int'(fireboy_data), m_hit_prev ? int'(rom_mem[12'(m_addr_prev)]) : 0);
    endtask

    task automatic fs_pulse(input int x, input int y);
        frame_clk = 1'b1;
        tick(x, y);
        frame_clk = 1'b0;
        tick(x, y);
    endtask

    task automatic async_reset();
        #3 Reset_n = 1'b0;
        #1;
        chk("rst_rom_addr", int'(rom_if.rom_addr), 0);
        chk("rst_is_fireboy", int'(is_fireboy), 0);
        chk("rst_data", int'(fireboy_data), 0);
        @(posedge Clk);
        @(posedge Clk);
        #4 Reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
        model_reset();
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_rom_addr", int'(rom_if.rom_addr), 0);
        chk("rst_is_fireboy", int'(is_fireboy), 0);
        chk("rst_data", int'(fireboy_data), 0);
        @(posedge Clk);
        @(posedge Clk);
        #4 Reset_n = 1'b1;
        // latched pose is (0,0) out of reset, anim frame 0
        tick(5, 3);
        chk("rst_pose_addr", int'(rom_if.rom_addr), 77);
        tick(0, 0);
        tick(0, 0);

        // hit window around (100,50)
        fireboy_x = 10'd100; fireboy_y = 10'd50;
        fs_pulse(0, 0);
        for (int x = 99; x <= 124; x++) tick(x, 50);
        tick(0, 0);
        tick(0, 0);

        // mirrored fetch
        facing_left = 1'b1;
        fs_pulse(0, 0);
        tick(100, 51);
        chk("mirror_addr", int'(rom_if.rom_addr), 47);
        tick(0, 0);
        tick(0, 0);

        // right-edge clip: no wrap to column 0
        facing_left = 1'b0;
        fireboy_x = 10'd630; fireboy_y = 10'd0;
        fs_pulse(300, 300);
        tick(639, 0);
        chk("clip_addr", int'(rom_if.rom_addr), 9);
        tick(0, 0);
        tick(0, 0);
        chk("clip_nowrap", int'(is_fireboy), 0);
        tick(0, 0);

        // animation: 30 moving frame starts, then drop moving on the step
        fireboy_x = 10'd100; fireboy_y = 10'd50;
        moving = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            fs_pulse(100, 50);
            if (n == 6) chk("anim_first_step", int'(rom_if.rom_addr), 768);
            if (n == 30) chk("anim_frame_30", int'(rom_if.rom_addr), 2 * 768);
        end
        for (int n = 0; n < 5; n++) fs_pulse(100, 50);
        moving = 1'b0;
        fs_pulse(100, 50);
        chk("anim_drop", int'(rom_if.rom_addr), 0);

        // position change without a frame start must not move the box
        fireboy_x = 10'd300;
        for (int x = 98; x <= 126; x++) tick(x, 60);
        fs_pulse(0, 0);
        for (int x = 298; x <= 326; x++) tick(x, 60);

        // randomized scan with occasional frame starts, pose changes and a reset
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                fireboy_x = 10'($urandom_range(0, 1023));
                fireboy_y = 10'($urandom_range(0, 1023));
            end
            if ($urandom_range(0, 60) == 0) facing_left = ~facing_left;
            if ($urandom_range(0, 80) == 0) moving = ~moving;
            frame_clk = ($urandom_range(0, 7) == 0);
            if (i == 1000) async_reset();
            if ($urandom_range(0, 3) == 0)
                tick($urandom_range(0, 1023), $urandom_range(0, 1023));
            else
                tick((m_x + $urandom_range(0, 30) + 1019) % 1024, (m_y + $urandom_range(0, 38) + 1019) % 1024);
        end
        frame_clk = 1'b0;
        tick(0, 0);
        tick(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fireboy_sprite_fetch.md
Name: fireboy_sprite_fetch

Overview:
- Per-pixel sprite fetch stage directly upstream of the VGA colour mapper; produces is_fireboy and fireboy_data (4-bit palette index, zero-extended to 8 bits) for the current scan position.
- Latches Fireboy position and pose once per frame; runs a walk-animation frame counter.
- Generates sprite ROM addresses, with horizontal mirroring when facing left.
- Two-cycle pipeline; top level delays DrawX/DrawY-aligned sync signals by PIPE_LAT to match.

Parameters:
- SPRITE_W, 24, sprite width in pixels.
- SPRITE_H, 32, sprite height in pixels.
- NUM_FRAMES, 4, walk-animation frames stored consecutively in ROM (frame 0 = idle).
- ANIM_DIV, 6, video frames per animation step.
- ROM_AW, 12, sprite ROM address width; must hold NUM_FRAMES*SPRITE_W*SPRITE_H.

Ports:
- Clk  in  1  pixel clock; DrawX advances once per Clk.
- Reset_n  in  1  asynchronous active-low reset.
- frame_clk  in  1  vertical-sync pulse, synchronous to Clk; rising edge marks frame start.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- fireboy_x  in  10  top-left X from physics.
- fireboy_y  in  10  top-left Y from physics.
- facing_left  in  1  mirror sprite horizontally.
- moving  in  1  walking; enables animation.
- rom_addr  out  ROM_AW  sprite ROM address, registered.
- rom_data  in  4  ROM palette index, valid 1 cycle after rom_addr.
- is_fireboy  out  1  pixel lies inside sprite box.
- fireboy_data  out  8  {4'b0, palette index}; 0 = transparent.

Behaviour:
- Reset (async, Reset_n=0) clears everything: rom_addr=0, is_fireboy=0, fireboy_data=0, latched pos=(0,0), latched facing=0, anim_frame=0, frame divider=0, frame_clk edge register=0.
- Frame-start detection: fs = frame_clk & ~frame_clk_q.
- On fs, latch fireboy_x, fireboy_y and facing_left. All geometry uses only these latched values, so there is no mid-frame tearing.
- Animation runs on fs only:
  - If moving=0: divider<=0, anim_frame<=0. This takes priority on the same fs as a would-be step.
  - Else if divider==ANIM_DIV-1: divider<=0; anim_frame<=anim_frame+1, wrapping from NUM_FRAMES-1 to 1, never 0.
  - Else divider<=divider+1.
- Stage 1 (cycle after DrawX/DrawY are presented):
  - hit = DrawX>=px && DrawX<px+SPRITE_W && DrawY>=py && DrawY<py+SPRITE_H.
  - Compute the sums in 11 bits so a sprite past x=639 or y=479 never wraps.
  - col = DrawX-px, mirrored to SPRITE_W-1-col when facing; row = DrawY-py.
  - rom_addr <= hit ? anim_frame*SPRITE_W*SPRITE_H + row*SPRITE_W + col : rom_addr (hold).
  - hit_q <= hit.
- Stage 2: is_fireboy <= hit_q; fireboy_data <= hit_q ? {4'b0, rom_data} : 8'h00.
- Total latency PIPE_LAT=2 cycles, DrawX to outputs; one result per cycle with no stalls.
- anim_frame changing at fs does not corrupt in-flight pixels: each pixel uses the anim_frame current at its stage 1.
- Pixel coordinates ≥640 or ≥480 are treated like any other; hit is decided purely by compare.

Decomposition:
- Package fib_video_pkg holds:
  - H_VISIBLE=640, V_VISIBLE=480.
  - PIPE_LAT=2.
  - TRANSPARENT_IDX=4'd0.
  - typedef pal_idx_t (logic [3:0]).
  - typedef sprite_pose_t struct {x, y, facing}.
- One sub-module: fireboy_anim_ctr, covering the frame-edge detect, divider and anim_frame. The address pipeline stays in the parent.

Test Plan:
- Reset: hold Reset_n=0 mid-line, then release -> rom_addr=0, is_fireboy=0, fireboy_data=0 on the cycle of assertion; anim_frame=0.
- Hit window: pos (100,50) latched by fs; scan DrawY=50, DrawX=99..124 -> is_fireboy=1 exactly for DrawX=100..123, observed 2 cycles later; rom_addr 0..23.
- Mirror: facing_left=1, DrawX=100, DrawY=51 -> rom_addr=24+23=47; fireboy_data equals ROM model value at 47.
- Right-edge clip: pos (630,0), DrawX=639 -> hit (col 9); DrawX=0 on the same row -> no hit (no wrap).
- Animation: moving=1 for 30 fs pulses -> anim_frame sequence 0→1 after 6, then 2, 3, 1, 2. Drop moving at the step fs -> anim_frame=0.
- Latching: change fireboy_x mid-frame without fs -> hit window unchanged until the next fs.
